// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and lane helpers for the memory stage: access sizes,
// FSM states, alignment test, store byte-enable and store lane replication.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lo[0];
            default:   return (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load formatter: moves the addressed lane down to bit 0, truncates to the
// access size and sign- or zero-extends it. Word accesses ignore is_unsigned.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns EX/MEM load/store control into a word-aligned bus
// request/ack transaction, formats load data and stalls the pipeline until done.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    state_e               state_q, state_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [31:0]          bus_wdata_q, bus_wdata_d;
    logic [3:0]           bus_byte_en_q, bus_byte_en_d;
    logic [31:0]          load_data_q, load_data_d;
    logic                 bus_error_q, bus_error_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [1:0]           lane_q, lane_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 access_req;
    logic                 fault;
    logic                 timeout;
    logic [31:0]          rdata_fmt;

    // Size and lane are latched at launch so formatting does not depend on
    // EX/MEM staying frozen for the whole access.
    load_align u_load_align (
        .rdata       (bus_rdata),
        .addr_lo     (lane_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (rdata_fmt)
    );

    always_comb begin
        access_req    = mem_read | mem_write;
        fault         = addr_misaligned(mem_size, addr[1:0]);
        timeout       = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_byte_en_d = bus_byte_en_q;
        load_data_d   = load_data_q;
        bus_error_d   = 1'b0;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        lane_d        = lane_q;
        cnt_d         = cnt_q;
        stall         = 1'b0;
        misaligned    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                misaligned = access_req & fault;
                if (access_req && fault) begin
                    load_data_d = '0;
                end else if (access_req) begin
                    stall         = 1'b1;
                    state_d       = ST_ACCESS;
                    bus_req_d     = 1'b1;
                    bus_we_d      = mem_write;
                    bus_addr_d    = {addr[31:2], 2'b00};
                    bus_byte_en_d = lane_enables(mem_size, addr[1:0]);
                    bus_wdata_d   = lane_data(mem_size, store_data);
                    size_d        = mem_size;
                    unsigned_d    = mem_unsigned;
                    lane_d        = addr[1:0];
                    cnt_d         = '0;
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        load_data_d = rdata_fmt;
                    end
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                end else if (timeout) begin
                    load_data_d = '0;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_byte_en_q <= '0;
            load_data_q   <= '0;
            bus_error_q   <= 1'b0;
            size_q        <= SIZE_WORD;
            unsigned_q    <= 1'b0;
            lane_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_byte_en_q <= bus_byte_en_d;
            load_data_q   <= load_data_d;
            bus_error_q   <= bus_error_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            lane_q        <= lane_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_byte_en = bus_byte_en_q;
    assign bus_error   = bus_error_q;
    // A faulting access must present zero to MEM_WB in the same cycle.
    assign load_data   = misaligned ? '0 : load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// aligned accesses checked against a byte-arithmetic reference model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, store_data;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
    logic [3:0]  bus_byte_en;
    logic        stall, misaligned, bus_error;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ld;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
        .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .load_data(load_data),
        .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    // Reference model: byte arithmetic straight from the access rules.
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] s, input int off);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(s));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(s)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] s,
                                             input int off, input logic uns);
        longint v;
        int n;
        n = nbytes(s);
        v = ({32'd0, rd} >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one access and records what was observed; callers compare.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] sd,
                             input int ack_wait, input logic [31:0] rdata,
                             output int stall_cycles, output int acc_cnt,
                             output logic [31:0] b_addr, output logic [31:0] b_wdata,
                             output logic [3:0] b_be, output logic b_we,
                             output logic stable, output logic [31:0] ld_done,
                             output int err_cnt, output logic done_ok,
                             output logic done_req);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; store_data = sd; bus_ack = 1'b0;
        stall_cycles = 0; acc_cnt = 0; stable = 1'b1; err_cnt = 0;
        done_ok = 1'b0; done_req = 1'b1; ld_done = 'x;
        b_addr = 'x; b_wdata = 'x; b_be = 'x; b_we = 1'bx;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus_error === 1'b1) err_cnt++;
            if (stall !== 1'b1) begin
                done_ok  = (cyc > 0);
                ld_done  = load_data;
                done_req = bus_req;
                break;
            end
            stall_cycles++;
            if (bus_req === 1'b1) begin
                if (acc_cnt == 0) begin
                    b_addr = bus_addr; b_wdata = bus_wdata; b_be = bus_byte_en; b_we = bus_we;
                end else if (bus_addr !== b_addr || bus_wdata !== b_wdata ||
                             bus_byte_en !== b_be || bus_we !== b_we) begin
                    stable = 1'b0;
                end
                bus_ack   = (acc_cnt == ack_wait);
                bus_rdata = bus_ack ? rdata : $urandom();
                acc_cnt++;
            end
            tick();
            bus_ack = 1'b0;
            #1;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
        if (bus_error === 1'b1) err_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
        mem_unsigned = 1'b0; addr = '0; store_data = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) tick();
        checks++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_error !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b we=%b err=%b stall=%b required 0000",
                     bus_req, bus_we, bus_error, stall);
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_byte_en !== 4'h0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%b ld=%h required all zero",
                     bus_addr, bus_wdata, bus_byte_en, load_data);
        end
        reset = 1'b0;
        tick();
        exp_ld = '0;
    endtask

    task automatic test_word_load();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        do_access(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || ba !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            errors++;
            $display("FAIL word_load_bus: ok=%b addr=%h be=%b we=%b required 1 00000100 1111 0", ok, ba, be, we);
        end
        checks++;
        if (sc != 2 || ac != 1) begin
            errors++;
            $display("FAIL word_load_stall: stall=%0d req=%0d required 2 1", sc, ac);
        end
        checks++;
        if (ld !== 32'hDEADBEEF || dr !== 1'b0) begin
            errors++;
            $display("FAIL word_load_data: ld=%h req=%b required deadbeef 0", ld, dr);
        end
        exp_ld = 32'hDEADBEEF;
    endtask

    task automatic test_misaligned();
        logic saw_req;
        mem_read = 1'b1; mem_size = 2'd2; mem_unsigned = 1'b0; addr = 32'h102;
        #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_flags: mis=%b stall=%b ld=%h required 1 0 00000000",
                     misaligned, stall, load_data);
        end
        saw_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_req !== 1'b0 || stall !== 1'b0) saw_req = 1'b1;
        end
        checks++;
        if (saw_req) begin
            errors++;
            $display("FAIL misaligned_nobus: got bus_req or stall high, required none");
        end
        mem_read = 1'b0;
        mem_size = 2'd1; mem_write = 1'b1; addr = 32'h201;
        #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_half: mis=%b stall=%b required 1 0", misaligned, stall);
        end
        mem_write = 1'b0;
        tick();
        exp_ld = '0;
    endtask

    task automatic test_byte_load();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        do_access(1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 32'h80000000,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || ld !== 32'hFFFFFF80 || be !== 4'b1000 || ba !== 32'h100) begin
            errors++;
            $display("FAIL byte_load_signed: ld=%h be=%b addr=%h required ffffff80 1000 00000100", ld, be, ba);
        end
        do_access(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 32'h80000000,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || ld !== 32'h00000080 || sc != 3) begin
            errors++;
            $display("FAIL byte_load_unsigned: ld=%h stall=%0d required 00000080 3", ld, sc);
        end
        exp_ld = 32'h00000080;
    endtask

    task automatic test_half_store();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        do_access(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 3, 32'h11111111,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || we !== 1'b1 || be !== 4'b1100 || bw !== 32'hABCDABCD || ba !== 32'h200) begin
            errors++;
            $display("FAIL half_store_bus: we=%b be=%b wdata=%h addr=%h required 1 1100 abcdabcd 00000200",
                     we, be, bw, ba);
        end
        checks++;
        if (!st || sc != 5 || ac != 4) begin
            errors++;
            $display("FAIL half_store_timing: stable=%b stall=%0d req=%0d required 1 5 4", st, sc, ac);
        end
        checks++;
        if (ld !== exp_ld) begin
            errors++;
            $display("FAIL half_store_ld_hold: ld=%h required %h", ld, exp_ld);
        end
    endtask

    task automatic test_timeout();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        do_access(1, 0, 2'd2, 0, 32'h400, 32'h0, -1, 32'h0,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || ac != 16 || sc != 17) begin
            errors++;
            $display("FAIL timeout_len: ok=%b req=%0d stall=%0d required 1 16 17", ok, ac, sc);
        end
        checks++;
        if (ec != 1 || ld !== 32'h0 || dr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err_pulses=%0d ld=%h req=%b required 1 00000000 0", ec, ld, dr);
        end
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: stall=%b req=%b required 0 0", stall, bus_req);
        end
        exp_ld = '0;
    endtask

    task automatic test_reset_mid_access();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        mem_read = 1'b1; mem_size = 2'd2; mem_unsigned = 1'b0; addr = 32'h300;
        tick();
        tick();
        checks++;
        if (bus_req !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_active: req=%b stall=%b required 1 1", bus_req, stall);
        end
        reset = 1'b1; mem_read = 1'b0;
        tick();
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_drop: req=%b stall=%b ld=%h required 0 0 00000000", bus_req, stall, load_data);
        end
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        tick();
        bus_ack = 1'b0;
        tick();
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ack: req=%b stall=%b ld=%h err=%b required 0 0 00000000 0",
                     bus_req, stall, load_data, bus_error);
        end
        do_access(1, 0, 2'd2, 0, 32'h304, 32'h0, 1, 32'hCAFEF00D,
                  sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
        checks++;
        if (!ok || ld !== 32'hCAFEF00D || sc != 3 || ba !== 32'h304) begin
            errors++;
            $display("FAIL rst_recover: ld=%h stall=%0d addr=%h required cafef00d 3 00000304", ld, sc, ba);
        end
        exp_ld = 32'hCAFEF00D;
    endtask

    task automatic test_random();
        int sc, ac, ec; logic [31:0] ba, bw, ld; logic [3:0] be; logic we, st, ok, dr;
        logic [31:0] a, sd, rdv; logic [1:0] sz; logic wr, uns; int off, w;
        for (int t = 0; t < 30; t++) begin
            sz  = 2'($urandom_range(0, 3));
            off = (sz == 2'd0) ? int'($urandom_range(0, 3)) : (sz == 2'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
            a   = $urandom();
            a[1:0] = off[1:0];
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sd  = $urandom();
            rdv = $urandom();
            w   = int'($urandom_range(0, 4));
            do_access(!wr, wr, sz, uns, a, sd, w, rdv, sc, ac, ba, bw, be, we, st, ld, ec, ok, dr);
            if (!wr) exp_ld = ref_load(rdv, sz, off, uns);
            checks++;
            if (!ok || ba !== {a[31:2], 2'b00} || we !== wr || be !== ref_be(sz, off) ||
                (wr && bw !== ref_wdata(sz, sd))) begin
                errors++;
                $display("FAIL rand_bus[%0d]: addr=%h we=%b be=%b wdata=%h required %h %b %b %h",
                         t, ba, we, be, bw, {a[31:2], 2'b00}, wr, ref_be(sz, off), ref_wdata(sz, sd));
            end
            checks++;
            if (ld !== exp_ld || sc != w + 2 || !st || ec != 0) begin
                errors++;
                $display("FAIL rand_result[%0d]: ld=%h stall=%0d stable=%b err=%0d required %h %0d 1 0",
                         t, ld, sc, st, ec, exp_ld, w + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_misaligned();
        test_byte_load();
        test_half_store();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
